// File: rtl/conv_fetch_scheduler.sv
// conv_fetch_scheduler: walks the pixel ROM row-major for one frame and
// presents each word as a registered valid/ready pixel with end-of-line
// and K x K window-valid flags for the line buffers and kernel array.
module conv_fetch_scheduler #(
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int K          = 3,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] i_rom_data,
    input  logic                  i_pix_ready,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    output logic [DATA_WIDTH-1:0] o_pix_data,
    output logic                  o_pix_valid,
    output logic                  o_pix_eol,
    output logic                  o_win_valid,
    output logic                  o_frame_done,
    output logic                  o_busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [DATA_WIDTH-1:0] r_pix_data;
    logic                  r_pix_valid;
    logic                  r_pix_eol;
    logic                  r_win_valid;
    logic                  r_frame_done;
    logic                  r_busy;

    logic                  w_capture;    // load i_rom_data into the output register
    logic                  w_last;       // current address is the final pixel of the frame
    logic                  w_abort;      // enable dropped mid-frame
    logic                  w_drain_ack;  // final pixel accepted in DRAIN

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle strobes; abort takes priority over capture
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_drain_ack = 1'b0;
        w_last      = (r_col == COL_LAST) && (r_row == ROW_LAST);
        case (r_state)
            S_IDLE: begin
                if (i_enable) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (!i_enable) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!r_pix_valid || i_pix_ready) begin
                    w_capture = 1'b1;
                    if (w_last) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!i_enable) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (i_pix_ready) begin
                    w_drain_ack = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address walk, pixel register, flags and status; a stall holds everything
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_rom_addr   <= '0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_frame_done <= (w_state_nxt == S_DONE);
            r_busy       <= (w_state_nxt != S_IDLE);
            if (w_abort) begin
                r_pix_valid <= 1'b0;
                r_pix_eol   <= 1'b0;
                r_win_valid <= 1'b0;
                r_rom_addr  <= '0;
                r_col       <= '0;
                r_row       <= '0;
            end else if (w_capture) begin
                r_pix_data  <= i_rom_data;
                r_pix_valid <= 1'b1;
                r_pix_eol   <= (r_col == COL_LAST);
                r_win_valid <= (r_row >= ROW_WIN) && (r_col >= COL_WIN);
                if (w_last) begin
                    // Rewind so the next frame starts at address 0
                    r_rom_addr <= '0;
                    r_col      <= '0;
                    r_row      <= '0;
                end else begin
                    r_rom_addr <= r_rom_addr + ADDR_WIDTH'(1);
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + RW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end
            end else if (w_drain_ack) begin
                r_pix_valid <= 1'b0;
                r_pix_eol   <= 1'b0;
                r_win_valid <= 1'b0;
            end
        end
    end

    assign o_rom_addr   = r_rom_addr;
    assign o_pix_data   = r_pix_data;
    assign o_pix_valid  = r_pix_valid;
    assign o_pix_eol    = r_pix_eol;
    assign o_win_valid  = r_win_valid;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;

endmodule

// File: doc/conv_fetch_scheduler.md
# conv_fetch_scheduler

Sequences the external pixel ROM for one convolution layer frame. It walks the ROM address space row-major over an IMG_W x IMG_H image and registers each returned word into a valid/ready pixel stream for the conv datapath. Each pixel carries end-of-line and window-valid flags, so the line buffers and the 3x3 kernel array know when a full K x K window is present. The block sits between the asynchronous-read ROM (256x32) and the conv layer top, replacing its free-running address counter.

## Interface
- IMG_W, 16, image width in pixels
- IMG_H, 16, image height in pixels
- K, 3, kernel size; sets the window-valid threshold
- ADDR_WIDTH, 8, ROM address width; equals `EXT_ADDR_WIDTH; IMG_W*IMG_H <= 2**ADDR_WIDTH
- DATA_WIDTH, 32, pixel word width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  level; high starts or continues a frame, low aborts
- rom_data  in  DATA_WIDTH  combinational ROM output for rom_addr (spo)
- pix_ready  in  1  datapath accepts pix_data this cycle
- rom_addr  out  ADDR_WIDTH  registered ROM address
- pix_data  out  DATA_WIDTH  registered pixel
- pix_valid  out  1  pix_data valid
- pix_eol  out  1  pixel is the last column of its row
- win_valid  out  1  pixel completes a K x K window (row >= K-1 and col >= K-1)
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- busy  out  1  high in FETCH, DRAIN and DONE

## Operation
- Reset (async, rst_n=0) clears all outputs and counters:
  - rom_addr=0, pix_data=0, pix_valid=0, pix_eol=0, win_valid=0, frame_done=0, busy=0
  - state=IDLE, row=col=0
- FSM states and transitions:
  - IDLE -> FETCH when enable=1. rom_addr, row and col are already 0.
  - FETCH: a capture occurs on each edge where (!pix_valid || pix_ready). A capture does the following:
    - pix_data <= rom_data
    - pix_valid <= 1
    - pix_eol <= (col==IMG_W-1)
    - win_valid <= (row>=K-1 && col>=K-1)
    - rom_addr, col and row advance (col wraps at IMG_W-1 and increments row)
  - FETCH -> DRAIN on the capture of pixel IMG_W*IMG_H-1. rom_addr returns to 0 and row/col clear.
  - DRAIN: hold the last pixel until pix_ready. On acceptance, pix_valid <= 0, pix_eol <= 0, win_valid <= 0, then -> DONE.
  - DONE: frame_done=1 for exactly this cycle, then -> IDLE unconditionally. If enable is still high, IDLE starts a new frame on the following edge.
- Stall:
  - When pix_valid=1 and pix_ready=0, pix_data, the flags, rom_addr and the counters all hold.
  - rom_data is re-read, not buffered.
- Abort: enable=0 in FETCH or DRAIN -> next edge goes to IDLE.
  - pix_valid, pix_eol and win_valid clear; rom_addr, row and col clear.
  - frame_done is not pulsed.
- In IDLE and DONE no capture occurs and the ROM is not advanced.
- Simultaneous accept and capture in FETCH (pix_valid && pix_ready) gives full throughput: one pixel per cycle.
- win_valid count per frame = (IMG_W-K+1)*(IMG_H-K+1).
- Address arithmetic is unsigned, ADDR_WIDTH bits. rom_addr = row*IMG_W + col is maintained by increment, not by multiply.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Let enable be sampled high at edge k in IDLE. Then:
  - state=FETCH, busy=1 after edge k
  - first capture at edge k+1: pix_data = ROM[0], pix_valid=1
- With pix_ready tied to 1:
  - pixel n is presented after edge k+1+n
  - the last pixel is captured at edge k+IMG_W*IMG_H and accepted at edge k+IMG_W*IMG_H+1
  - frame_done is high after that edge for one cycle
  - busy falls at the next edge
- ROM read latency is zero (combinational). The address-to-data capture latency is 1 cycle.
- Reset assertion mid-frame: outputs clear immediately (asynchronously) and no frame_done is produced.

## Test plan
- ROM[i]=i, IMG 16x16, pix_ready=1, enable high at edge k:
  - 256 consecutive valids with pix_data 0..255
  - pix_eol on 15, 31, …, 255
  - win_valid on 196 pixels, the first on pix_data 34
  - frame_done single pulse after edge k+257; busy low after k+258
- Random pix_ready (50%):
  - stream still equals 0..255 in order with no duplicates or drops
  - pix_data and the flags stable throughout every stall
  - exactly one frame_done
- Last-pixel stall: pix_ready=0 for 5 cycles when pix_data=255. The block holds in DRAIN with valid=1; frame_done fires only after acceptance.
- Abort: enable drops after pixel 100 is presented.
  - pix_valid low and rom_addr=0 after the next edge; no frame_done
  - re-enable restarts with pix_data=0
- Back-to-back frames: enable held high. The second frame's first capture occurs 2 edges after the first frame's frame_done pulse, with pix_data=0.
- Async reset asserted mid-FETCH between edges: all outputs read 0 before the next clock edge, and state is IDLE after release.
